pipeline_stall_controller: RTL and testbench



---
 rtl/pipeline_stall_controller.sv | 108 ++++++++++
 tb/tb_pipeline_stall_controller.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Central stall / bubble / flush / freeze sequencer for the 5-stage pipeline.
// Control outputs are Mealy functions of state, remaining and current inputs.
// Three saturating counters track stall, freeze and flush cycles.
module pipeline_stall_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_use_hz,
    input  logic [1:0]       branch_hz_cnt,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             stall_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] freeze_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state, state_nxt;
    logic [1:0] remaining, remaining_nxt;
    logic [1:0] n_req;

    // Requested stall length: a load-use hazard alone needs one cycle, and it
    // overlaps any branch operand wait rather than adding to it.
    always_comb begin
        n_req = branch_hz_cnt;
        if (load_use_hz && branch_hz_cnt == 2'd0)
            n_req = 2'd1;
    end

    // Next-state and control outputs; freeze beats stall, stall beats flush.
    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_write  = 1'b0;
        stall_busy    = 1'b0;
        if (rstn) begin
            stall_busy = (state == STALL);
            if (!dmem_busy) begin
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
                mem_wb_write = 1'b1;
                if (state == STALL) begin
                    id_ex_bubble = 1'b1;
                    if (remaining == 2'd1) begin
                        state_nxt     = RUN;
                        remaining_nxt = 2'd0;
                    end else begin
                        remaining_nxt = remaining - 2'd1;
                    end
                end else if (n_req != 2'd0) begin
                    id_ex_bubble = 1'b1;
                    if (n_req >= 2'd2) begin
                        state_nxt     = STALL;
                        remaining_nxt = n_req - 2'd1;
                    end
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = branch_taken;
                end
            end
        end
    end

    // State register; a reset mid-sequence drops straight back to RUN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= RUN;
            remaining <= 2'd0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cycles  <= '0;
            freeze_cycles <= '0;
            flush_count   <= '0;
        end else begin
            if (id_ex_bubble && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (dmem_busy && freeze_cycles != '1)
                freeze_cycles <= freeze_cycles + CNT_W'(1);
            if (if_id_flush && flush_count != '1)
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: a behavioural model pushes the expected control vector when
// each cycle's stimulus is driven; it is popped and compared mid-cycle.
module tb_pipeline_stall_controller;

    logic        clk = 1'b0;
    logic        rstn, load_use_hz, branch_taken, dmem_busy;
    logic [1:0]  branch_hz_cnt;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic        id_ex_write, ex_mem_write, mem_wb_write, stall_busy;
    logic [31:0] stall_cycles, freeze_cycles, flush_count;
    logic        s_pc, s_ifw, s_fl, s_bub, s_idx, s_exm, s_mwb, s_busy;
    logic [3:0]  s_stall, s_freeze, s_flush;

    pipeline_stall_controller #(.CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .load_use_hz(load_use_hz), .branch_hz_cnt(branch_hz_cnt),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .id_ex_write(id_ex_write), .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
        .stall_busy(stall_busy), .stall_cycles(stall_cycles), .freeze_cycles(freeze_cycles),
        .flush_count(flush_count));

    // Narrow-counter build sharing the same stimulus, used for saturation.
    pipeline_stall_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rstn(rstn), .load_use_hz(load_use_hz), .branch_hz_cnt(branch_hz_cnt),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy), .pc_write(s_pc),
        .if_id_write(s_ifw), .if_id_flush(s_fl), .id_ex_bubble(s_bub),
        .id_ex_write(s_idx), .ex_mem_write(s_exm), .mem_wb_write(s_mwb),
        .stall_busy(s_busy), .stall_cycles(s_stall), .freeze_cycles(s_freeze),
        .flush_count(s_flush));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state
    bit          m_stall;
    int          m_rem;
    longint      m_sc, m_fc, m_flc;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_exp;
    logic        last_pc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    // Expected {pc,ifw,flush,bubble,idex,exmem,memwb,busy}
    function automatic logic [7:0] model_out(input logic r, input logic lu, input logic [1:0] bh,
                                             input logic bt, input logic bz);
        int n;
        n = (lu && bh == 0) ? 1 : int'(bh);
        if (!r) return 8'b0000_0000;
        if (bz) return {7'b0, m_stall};
        if (m_stall) return 8'b0001_1111;
        if (n > 0) return 8'b0001_1110;
        return bt ? 8'b1110_1110 : 8'b1100_1110;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                id_ex_write, ex_mem_write, mem_wb_write, stall_busy};
    endfunction

    // One clock cycle: drive at negedge, score mid-low-phase, update model at posedge.
    task automatic step(input string tag, input logic r, input logic lu, input logic [1:0] bh,
                        input logic bt, input logic bz);
        logic [7:0] e;
        int n;
        @(negedge clk);
        rstn = r; load_use_hz = lu; branch_hz_cnt = bh; branch_taken = bt; dmem_busy = bz;
        if (!r) begin
            m_stall = 0; m_rem = 0; m_sc = 0; m_fc = 0; m_flc = 0;
        end
        exp_q.push_back(model_out(r, lu, bh, bt, bz));
        #2;
        e = exp_q.pop_front();
        chk({tag, ".ctl"}, 64'(dut_out()), 64'(e));
        chk({tag, ".stall_cnt"}, 64'(stall_cycles), 64'(m_sc));
        chk({tag, ".freeze_cnt"}, 64'(freeze_cycles), 64'(m_fc));
        chk({tag, ".flush_cnt"}, 64'(flush_count), 64'(m_flc));
        last_exp = e;
        last_pc = pc_write;
        @(posedge clk);
        if (r) begin
            n = (lu && bh == 0) ? 1 : int'(bh);
            if (e[4]) m_sc++;
            if (bz) m_fc++;
            if (e[5]) m_flc++;
            if (!bz) begin
                if (m_stall) begin
                    if (m_rem == 1) begin m_stall = 0; m_rem = 0; end
                    else m_rem--;
                end else if (n >= 2) begin
                    m_stall = 1; m_rem = n - 1;
                end
            end
        end
    endtask

    initial begin
        int first_high;
        rstn = 0; load_use_hz = 0; branch_hz_cnt = 0; branch_taken = 0; dmem_busy = 0;
        m_stall = 0; m_rem = 0; m_sc = 0; m_fc = 0; m_flc = 0;

        // Reset state, then idle
        step("rst", 0, 0, 0, 0, 0);
        step("rst_busy", 0, 1, 3, 1, 1);
        for (int i = 0; i < 5; i++) step("idle", 1, 0, 0, 0, 0);
        chk("idle.counters", 64'(stall_cycles + freeze_cycles + flush_count), 64'd0);

        // Single load-use pulse
        step("lu", 1, 1, 0, 0, 0);
        step("lu_after", 1, 0, 0, 0, 0);
        chk("lu.total", 64'(stall_cycles), 64'd1);

        // Branch hazard of 2 with taken branch ignored in STALL, then a flush
        step("bh2", 1, 0, 2, 0, 0);
        step("bh2_s", 1, 0, 0, 1, 0);
        chk("bh2.busy_in_stall", 64'(last_exp[0]), 64'd1);
        step("flush", 1, 0, 0, 1, 0);
        step("post_flush", 1, 0, 0, 0, 0);
        chk("flush.total", 64'(flush_count), 64'd1);

        // Stalled taken branch does not flush; combined request gives 3, not 4
        step("rst2", 0, 0, 0, 0, 0);
        step("bt_stalled", 1, 1, 0, 1, 0);
        step("lu_bh3", 1, 1, 3, 1, 0);
        step("lu_bh3_s1", 1, 1, 3, 0, 0);
        step("lu_bh3_s2", 1, 1, 3, 0, 0);
        step("lu_bh3_end", 1, 0, 0, 0, 0);
        chk("combo.stalls", 64'(stall_cycles), 64'd4);
        chk("combo.flush", 64'(flush_count), 64'd0);

        // bh=3 with a 4-cycle freeze on the second stall cycle
        step("rst3", 0, 0, 0, 0, 0);
        first_high = -1;
        for (int i = 0; i < 10; i++) begin
            step("frz", 1, 0, (i == 0) ? 2'd3 : 2'd0, 0, (i >= 2 && i <= 5));
            if (first_high < 0 && last_pc) first_high = i;
        end
        chk("frz.pc_return", 64'(first_high), 64'd7);
        chk("frz.stalls", 64'(stall_cycles), 64'd3);
        chk("frz.freezes", 64'(freeze_cycles), 64'd4);

        // Reset in the middle of a 3-cycle stall
        step("mid_req", 1, 0, 3, 0, 0);
        step("mid_rst", 0, 0, 0, 0, 0);
        step("mid_after", 1, 0, 0, 0, 0);
        step("mid_after2", 1, 0, 0, 0, 0);
        chk("mid.stall_cnt", 64'(stall_cycles), 64'd0);

        // Saturation on the narrow build
        step("rst4", 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step("sat", 1, 1, 0, 0, 0);
        step("sat_end", 1, 0, 0, 0, 0);
        chk("sat.wide", 64'(stall_cycles), 64'd20);
        chk("sat.narrow", 64'(s_stall), 64'd15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
